param_stack: RTL

PARAM_STACK -- requirements
Module: param_stack

---
 rtl/param_stack.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
//   Parameterised LIFO stack with a registered pop output and a combinational
//   peek of the current top entry.
//
//   Parameters
//     WIDTH     data word width in bits (>=1)
//     DEPTH     number of storage entries (>=2)
//     AF_LEVEL  Count threshold at which Almost_Full asserts (1..DEPTH)
//     CW        width of Count, clog2(DEPTH+1) (derived, not overridable)
//
//   Ports
//     Clk          in   sole clock, rising edge
//     RstN         in   synchronous active-low reset
//     Clear        in   synchronous flush of contents and error flags
//     Data_In      in   word to push
//     Push / Pop   in   requests, sampled each rising edge
//     Data_Out     out  registered value of the last popped word
//     Out_Valid    out  one-cycle pulse after an accepted pop
//     Top          out  current top entry, 0 when empty
//     Count        out  number of occupied entries
//     Full, Empty, Almost_Full   out  occupancy status decoded from Count
//     Overflow, Underflow        out  sticky error flags
//
//   Build option
//     PARAM_STACK_ERR_FLAGS_EN  when defined, Overflow/Underflow are sticky
//     registers; when undefined both outputs are constant 0.
// -----------------------------------------------------------------------------
module param_stack #(
  parameter int  WIDTH    = 8,
  parameter int  DEPTH    = 8,
  parameter int  AF_LEVEL = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Push,
  input  logic             Pop,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Top,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Empty,
  output logic             Almost_Full,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;

  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count_m1;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_free_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_active;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_replace;
  logic             w_wr_en;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_count_m1 = r_count - CW'(1);
  // Count never exceeds DEPTH, so the low AW bits address the array directly.
  assign w_top_idx  = w_count_m1[AW-1:0];
  assign w_free_idx = r_count[AW-1:0];

  // Reset and Clear both suppress any request presented in the same cycle.
  assign w_active    = RstN && !Clear;
  // Push+Pop on an empty stack degenerates to a plain push.
  assign w_push_only = w_active && Push && (!Pop || w_empty) && !w_full;
  assign w_pop_only  = w_active && Pop && !Push && !w_empty;
  // Push+Pop on a non-empty stack (full included) swaps the top entry.
  assign w_replace   = w_active && Push && Pop && !w_empty;
  assign w_wr_en     = w_push_only || w_replace;
  assign w_wr_idx    = w_replace ? w_top_idx : w_free_idx;

  // Storage is never reset; stale entries are hidden because Top is masked
  // while empty and reads only happen below Count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk) begin
        if (w_wr_en && (w_wr_idx == AW'(gi))) begin
          r_mem[gi] <= Data_In;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (Clear) begin
      // Data_Out deliberately keeps the last popped word across a flush.
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_pop_only || w_replace;
      if (w_pop_only || w_replace) begin
        r_data_out <= r_mem[w_top_idx];
      end
      if (w_push_only) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_only) begin
        r_count <= w_count_m1;
      end
    end
  end

`ifdef PARAM_STACK_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge Clk) begin
    if (!RstN || Clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (Push && !Pop && w_full) begin
        r_overflow <= 1'b1;
      end
      if (Pop && !Push && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;
`else
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif

  assign Data_Out    = r_data_out;
  assign Out_Valid   = r_out_valid;
  assign Count       = r_count;
  assign Full        = w_full;
  assign Empty       = w_empty;
  assign Almost_Full = (r_count >= CW'(AF_LEVEL));
  assign Top         = w_empty ? '0 : r_mem[w_top_idx];

endmodule
